// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared RV32I opcodes, FSM state encoding and datapath select codes
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_st_fetch     = 3'd0;
    localparam logic [2:0] c_st_decode    = 3'd1;
    localparam logic [2:0] c_st_execute   = 3'd2;
    localparam logic [2:0] c_st_memory    = 3'd3;
    localparam logic [2:0] c_st_writeback = 3'd4;

    localparam logic [1:0] c_pcsrc_pc4  = 2'd0;
    localparam logic [1:0] c_pcsrc_alu  = 2'd1;
    localparam logic [1:0] c_pcsrc_jalr = 2'd2;

    localparam logic [1:0] c_srca_pc   = 2'd0;
    localparam logic [1:0] c_srca_rs1  = 2'd1;
    localparam logic [1:0] c_srca_zero = 2'd2;

    localparam logic [1:0] c_srcb_rs2  = 2'd0;
    localparam logic [1:0] c_srcb_four = 2'd1;
    localparam logic [1:0] c_srcb_imm  = 2'd2;

    localparam logic [1:0] c_aluop_add    = 2'd0;
    localparam logic [1:0] c_aluop_branch = 2'd1;
    localparam logic [1:0] c_aluop_funct  = 2'd2;

    localparam logic [1:0] c_mtr_alu = 2'd0;
    localparam logic [1:0] c_mtr_mem = 2'd1;
    localparam logic [1:0] c_mtr_pc4 = 2'd2;

    function automatic logic opcode_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: opcode_known = 1'b1;
            default:                                      opcode_known = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Purpose  : Control bundle between the multi-cycle FSM and datapath/memory
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic [31:0] instruction;
    logic        mem_ack;
    logic        branch_taken;
    logic        mem_read;
    logic        mem_write;
    logic        lorD;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  aluop;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        illegal_instr;
    logic        bus_error;

    modport master (
        input  instruction, mem_ack, branch_taken,
        output mem_read, mem_write, lorD, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
               illegal_instr, bus_error
    );

    modport slave (
        output instruction, mem_ack, branch_taken,
        input  mem_read, mem_write, lorD, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
               illegal_instr, bus_error
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_counter
// Purpose  : Watchdog counting wait cycles of a pending memory request
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_count;

    // expired flags the TIMEOUT_CYCLES-th wait cycle, so an ack there still wins
    assign expired = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Main FSM of the multi-cycle RV32I core (FETCH..WRITEBACK)
// Revision : 1.0 - initial release
// ============================================================================
import core_pkg::*;

module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input wire logic                    clk,
    input wire logic                    reset,
    multicycle_control_unit_if.master   bus
);
    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [6:0] w_opcode;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_req;
    logic       w_expired;
    logic       w_timeout;
    logic       w_unused_instr;

    assign w_opcode       = bus.instruction[6:0];
    assign w_unused_instr = ^bus.instruction[31:7];
    assign w_is_load      = (w_opcode == OP_LOAD);
    assign w_is_store     = (w_opcode == OP_STORE);
    assign w_req          = (r_state == c_st_fetch) ||
                            ((r_state == c_st_memory) && (w_is_load || w_is_store));
    assign w_timeout      = w_req && w_expired && !bus.mem_ack;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .rst     (reset),
        .clear   (!w_req || bus.mem_ack || w_timeout),
        .enable  (w_req && !bus.mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_fetch: begin
                if (bus.mem_ack)    w_next_state = c_st_decode;
                else if (w_timeout) w_next_state = c_st_fetch;
            end
            c_st_decode: begin
                w_next_state = opcode_known(w_opcode) ? c_st_execute : c_st_fetch;
            end
            c_st_execute: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE:                          w_next_state = c_st_memory;
                    OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_next_state = c_st_writeback;
                    default:                                    w_next_state = c_st_fetch;
                endcase
            end
            c_st_memory: begin
                if (!(w_is_load || w_is_store)) w_next_state = c_st_fetch;
                else if (bus.mem_ack)           w_next_state = w_is_load ? c_st_writeback : c_st_fetch;
                else if (w_timeout)             w_next_state = c_st_fetch;
            end
            default: w_next_state = c_st_fetch;
        endcase
    end

    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.lorD          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_source     = c_pcsrc_pc4;
        bus.alu_src_a     = c_srca_pc;
        bus.alu_src_b     = c_srcb_rs2;
        bus.aluop         = c_aluop_add;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = c_mtr_alu;
        bus.illegal_instr = 1'b0;
        bus.bus_error     = 1'b0;
        // Reset forces every enable low, including mid-instruction aborts
        if (!reset) begin
            bus.bus_error = w_timeout;
            case (r_state)
                c_st_fetch: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ack;
                    bus.pc_write = bus.mem_ack;
                end
                c_st_decode: begin
                    bus.illegal_instr = !opcode_known(w_opcode);
                end
                c_st_execute: begin
                    case (w_opcode)
                        OP_R: begin
                            bus.aluop = c_aluop_funct; bus.alu_src_a = c_srca_rs1;
                            bus.alu_src_b = c_srcb_rs2;
                        end
                        OP_I: begin
                            bus.aluop = c_aluop_funct; bus.alu_src_a = c_srca_rs1;
                            bus.alu_src_b = c_srcb_imm;
                        end
                        OP_LUI:   begin bus.alu_src_a = c_srca_zero; bus.alu_src_b = c_srcb_imm; end
                        OP_AUIPC: begin bus.alu_src_a = c_srca_pc;   bus.alu_src_b = c_srcb_imm; end
                        OP_LOAD, OP_STORE: begin
                            bus.alu_src_a = c_srca_rs1; bus.alu_src_b = c_srcb_imm;
                        end
                        OP_BRANCH: begin
                            bus.aluop     = c_aluop_branch;
                            bus.alu_src_a = c_srca_pc;   bus.alu_src_b = c_srcb_imm;
                            bus.pc_write  = bus.branch_taken;
                            bus.pc_source = c_pcsrc_alu;
                        end
                        OP_JAL: begin
                            bus.alu_src_a = c_srca_pc;   bus.alu_src_b = c_srcb_imm;
                            bus.pc_write  = 1'b1;        bus.pc_source = c_pcsrc_alu;
                        end
                        OP_JALR: begin
                            bus.alu_src_a = c_srca_rs1;  bus.alu_src_b = c_srcb_imm;
                            bus.pc_write  = 1'b1;        bus.pc_source = c_pcsrc_jalr;
                        end
                        default: ;
                    endcase
                end
                c_st_memory: begin
                    bus.lorD      = 1'b1;
                    bus.mem_read  = w_is_load;
                    bus.mem_write = w_is_store;
                    bus.alu_src_a = c_srca_rs1;
                    bus.alu_src_b = c_srcb_imm;
                end
                c_st_writeback: begin
                    bus.reg_write = 1'b1;
                    if (w_is_load)                                    bus.mem_to_reg = c_mtr_mem;
                    else if (w_opcode == OP_JAL || w_opcode == OP_JALR) bus.mem_to_reg = c_mtr_pc4;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
